// File: rtl/keypad_defs_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM states, geometry,
// key-code layout and the row priority decoder.
package keypad_defs_pkg;

    localparam int KEY_W   = 4;
    localparam int N_LINES = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    typedef struct packed {
        logic       pressed;
        logic [1:0] idx;
    } row_hit_t;

    // Hex-layout keypad: the key legend equals its row_idx*4 + col_idx code.
    localparam logic [KEY_W-1:0] KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3;
    localparam logic [KEY_W-1:0] KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7;
    localparam logic [KEY_W-1:0] KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB;
    localparam logic [KEY_W-1:0] KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF;

    // Active-low rows; when several are low the lowest index wins.
    function automatic row_hit_t decode_row(input logic [N_LINES-1:0] row_n);
        row_hit_t hit;
        hit = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (!row_n[i]) begin
                hit.pressed = 1'b1;
                hit.idx     = 2'(i);
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all-ones so
// idle pulled-up lines read as inactive straight out of reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages sample the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and one key code per press.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_defs_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int DEB_W   = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);

    logic [3:0] row_s;

    sync_2ff #(.WIDTH(N_LINES)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row),
        .q     (row_s)
    );

    state_e             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [3:0]         col_q, col_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [KEY_W-1:0]   cand_q, cand_d;
    logic [KEY_W-1:0]   key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_down_q, key_down_d;

    logic               tick;
    logic               advance;
    row_hit_t           hit;
    logic [KEY_W-1:0]   code;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);
    logic [REP_W-1:0] rep_q, rep_d;
`else
    // Repeat timing only matters when auto-repeat is built in.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

    // Rows are sampled on the last cycle of each dwell, once the synchroniser has settled.
    assign tick = (dwell_q == DWELL_LAST);
    assign hit  = decode_row(row_s);
    assign code = {hit.idx, col_idx_q};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        dwell_d     = tick ? '0 : dwell_q + DWELL_W'(1);
        col_idx_d   = col_idx_q;
        deb_d       = deb_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        advance     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
`endif

        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (hit.pressed) begin
                        cand_d  = code;
                        deb_d   = DEB_W'(1);
                        state_d = ST_DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (hit.pressed && code == cand_q) begin
                        if (deb_q == DEB_LAST) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            state_d     = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d       = '0;
`endif
                        end else begin
                            deb_d = deb_q + DEB_W'(1);
                        end
                    end else begin
                        state_d = ST_SCAN;
                        advance = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!hit.pressed) begin
                        deb_d   = DEB_W'(1);
                        state_d = ST_RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_q == REP_LAST) begin
                        key_valid_d = 1'b1;
                        rep_d       = REP_RELOAD;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
`endif
                end
                ST_RELEASE: begin
                    if (hit.pressed) begin
                        state_d = ST_HELD;
                    end else if (deb_q == DEB_LAST) begin
                        key_down_d = 1'b0;
                        state_d    = ST_SCAN;
                        advance    = 1'b1;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end

        if (advance) begin
            col_idx_d = col_idx_q + 2'd1;
        end
        col_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            dwell_q     <= '0;
            col_idx_q   <= '0;
            col_q       <= 4'b1110;
            deb_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            deb_q       <= deb_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_CNT=3) with a keypad model
// that pulls a row low only while that key's column is driven low.
module tb_keypad_scan;

    logic        clk;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] key_mask;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;

    keypad_scan #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key index r*4+c connects row r to column c.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            cycles++;
            if (key_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_release(input int budget, output bit ok);
        int cycles;
        cycles = 0;
        ok = 1'b0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            cycles++;
            if (key_down === 1'b0) ok = 1'b1;
        end
    endtask

    initial begin
        logic [3:0] exp_cols [5];
        int  lat;
        bit  ok;

        exp_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        reset    = 1'b1;
        key_mask = '0;
        repeat (3) @(negedge clk);
        check("rst_col", col, 4'b1110);
        check("rst_code", key_code, 4'd0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_down", key_down, 1'b0);
        reset = 1'b0;

        // Idle scan: one column step every 4 cycles.
        check("scan_col0", col, exp_cols[0]);
        for (int i = 1; i < 5; i++) begin
            repeat (4) @(negedge clk);
            check($sformatf("scan_col%0d", i), col, exp_cols[i]);
        end
        check("idle_no_valid", valid_cnt, 0);
        check("idle_down", key_down, 1'b0);

        // Clean press of key 9 (row 2, col 1); column 1 comes round 4 cycles later.
        key_mask[9] = 1'b1;
        wait_valid(100, lat, ok);
        check("k9_seen", ok, 1'b1);
        check("k9_latency", lat, 16);
        check("k9_code", key_code, 4'd9);
        check("k9_down", key_down, 1'b1);
        @(negedge clk);
        check("k9_pulse_width", key_valid, 1'b0);
        check("k9_count", valid_cnt, 1);
        check("k9_col_frozen", col, 4'b1101);
        repeat (19) @(negedge clk);
        check("k9_col_frozen_late", col, 4'b1101);
        check("k9_still_down", key_down, 1'b1);

        // Release glitch spanning one sample, then pressed again.
        key_mask[9] = 1'b0;
        repeat (4) @(negedge clk);
        key_mask[9] = 1'b1;
        repeat (16) @(negedge clk);
        check("glitch_down", key_down, 1'b1);
        check("glitch_no_revalid", valid_cnt, 1);
        check("glitch_code", key_code, 4'd9);

        // Real release: key_down drops on the third quiet sample, scan resumes at col 2.
        key_mask[9] = 1'b0;
        repeat (11) @(negedge clk);
        check("rel_down_before", key_down, 1'b1);
        @(negedge clk);
        check("rel_down_after", key_down, 1'b0);
        check("rel_col2", col, 4'b1011);

        // Bounce on key 3 (row 0, col 3), toggling once per sample while col 3 is due.
        repeat (4) @(negedge clk);
        key_mask[3] = 1'b1;
        repeat (4) @(negedge clk);
        key_mask[3] = 1'b0;
        repeat (4) @(negedge clk);
        key_mask[3] = 1'b1;
        repeat (4) @(negedge clk);
        key_mask[3] = 1'b0;
        repeat (4) @(negedge clk);
        check("bounce_no_valid", valid_cnt, 1);
        check("bounce_no_down", key_down, 1'b0);
        key_mask[3] = 1'b1;
        wait_valid(100, lat, ok);
        check("k3_seen", ok, 1'b1);
        check("k3_latency", lat, 16);
        check("k3_code", key_code, 4'd3);
        @(negedge clk);
        check("k3_count", valid_cnt, 2);
        key_mask[3] = 1'b0;
        wait_release(100, ok);
        check("k3_released", ok, 1'b1);

        // Rows 1 and 3 together in column 0: row 1 wins.
        key_mask[4]  = 1'b1;
        key_mask[12] = 1'b1;
        wait_valid(100, lat, ok);
        check("multi_seen", ok, 1'b1);
        check("multi_code", key_code, 4'd4);
        @(negedge clk);
        check("multi_count", valid_cnt, 3);
        key_mask[4]  = 1'b0;
        key_mask[12] = 1'b0;
        wait_release(100, ok);
        check("multi_released", ok, 1'b1);

        // Reset while key 9 is held, then re-detection of the same key.
        key_mask[9] = 1'b1;
        wait_valid(100, lat, ok);
        check("pre_rst_seen", ok, 1'b1);
        check("pre_rst_code", key_code, 4'd9);
        repeat (8) @(negedge clk);
        check("pre_rst_down", key_down, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_col", col, 4'b1110);
        check("mid_rst_code", key_code, 4'd0);
        check("mid_rst_valid", key_valid, 1'b0);
        check("mid_rst_down", key_down, 1'b0);
        reset = 1'b0;
        wait_valid(100, lat, ok);
        check("post_rst_seen", ok, 1'b1);
        check("post_rst_code", key_code, 4'd9);
        @(negedge clk);
        check("post_rst_down", key_down, 1'b1);
        check("post_rst_count", valid_cnt, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart of the time-multiplexed seven-segment display driver.
- Drives the columns of a 4x4 matrix keypad one at a time, active-low, and reads back four active-low row lines.
- Debounces presses and releases, then reports one key code per accepted press.
- Sits beside disp_mux in board top levels; its key code feeds control logic, such as enable and direction for the rotating-box demo.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven (dwell). Minimum 4.
- DEBOUNCE_CNT, 8: consecutive matching scan samples needed to accept a press or a release. Minimum 2.
- REPEAT_DELAY, 50: samples held before auto-repeat starts. Used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE, 10: samples between repeat pulses. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- row  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
- col  output  4  column drive, active-low, one-hot-zero while scanning.
- key_code  output  4  last accepted key, encoded as row_idx*4 + col_idx.
- key_valid  output  1  one-cycle pulse when key_code is updated.
- key_down  output  1  high while the accepted key is held.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on reset; all state updates on the rising edge of clk.
- Reset values:
  - col = 4'b1110 (column 0).
  - key_code = 0, key_valid = 0, key_down = 0.
  - State SCAN; all counters 0; synchroniser flops set to 4'hF.
- row synchronisation: row passes through a 2-flop synchroniser before any use.
- Sample tick:
  - The dwell counter runs 0..SCAN_DIV-1 and wraps.
  - Sample tick = dwell counter at SCAN_DIV-1, i.e. the last cycle of the dwell, after the synchroniser has settled.
- Row decode:
  - At a tick, the synchronised row is "pressed" if any bit is 0.
  - If several bits are 0, the lowest row index wins.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - Tick with no press: col_idx increments mod 4; col = ~(1 << col_idx).
  - Tick with press: latch candidate = {row_idx, col_idx}; debounce counter = 1; go to DEBOUNCE. col_idx stays frozen.
- DEBOUNCE:
  - Tick with the same code: increment the counter.
  - When the counter reaches DEBOUNCE_CNT: key_code = candidate; key_valid pulses in the following cycle; key_down = 1; go to HELD.
  - Tick with no press or a different code: return to SCAN and advance col_idx. No output change.
- HELD:
  - col stays frozen.
  - Tick with no press: counter = 1; go to RELEASE.
  - Presses on other rows of the same column are ignored.
- RELEASE:
  - Tick with no press: increment the counter. At DEBOUNCE_CNT, key_down = 0; go to SCAN and advance col_idx.
  - Tick with any press: return to HELD. key_down stays 1; no key_valid.
- key_valid:
  - Exactly one cycle wide.
  - Never asserted in the same cycle as reset.
  - key_code is stable whenever key_valid = 0.
- Latency, press to key_valid: at most 4*SCAN_DIV + DEBOUNCE_CNT*SCAN_DIV + 3 cycles after the press is stable at the pins.
- Reset mid-operation:
  - Any state returns to the reset values on the next edge.
  - A key still held after reset is re-detected and re-reported as a fresh press.
- Counter widths: $clog2 of the parameter maximum. No overflow is possible because counters stop at their terminal counts.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- With the macro defined:
  - In HELD, a repeat counter counts ticks.
  - After REPEAT_DELAY ticks, key_valid pulses with an unchanged key_code, then again every REPEAT_RATE ticks while held.
  - The repeat counter clears on entering HELD from DEBOUNCE.
  - The repeat counter holds, rather than clears, during a RELEASE bounce that returns to HELD.
- Without the macro: exactly one key_valid per accepted press; the REPEAT_* parameters are unused.

Decomposition:
- Shared package/include keypad_defs:
  - State encodings: SCAN=2'd0, DEBOUNCE=2'd1, HELD=2'd2, RELEASE=2'd3.
  - Key-code width = 4; row/column count = 4.
  - Symbolic key codes for the hex-layout keypad.
- Sub-module sync_2ff: parameterised-width two-flop synchroniser with reset value all-ones. It is reused for other asynchronous inputs (switches, buttons).

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, keypad model drives row low only while its column is low):
- Reset, no key:
  - col cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, every 4 cycles.
  - key_valid never asserts; key_down = 0.
- Hold row 2 / col 1, clean press:
  - Exactly one key_valid with key_code = 9; key_down = 1.
  - col frozen at 1101 while held.
  - After release, key_down falls after 3 ticks and scanning resumes at col 2.
- Bounce: row 0 / col 3 toggles every tick for 5 ticks, then stable:
  - No key_valid during bouncing.
  - One key_valid with key_code = 3 after 3 stable ticks.
- Release glitch: while holding key 9, release for 1 tick, then press again:
  - key_down stays 1; no second key_valid.
- Rows 1 and 3 pressed simultaneously in col 0:
  - key_code = 4 (lowest row wins).
- Reset asserted in HELD with the key still down:
  - All outputs return to reset values the next cycle.
  - The key is re-reported: one key_valid, key_code unchanged.
  - With KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2: pulses at ticks 5, 7, 9... after acceptance.
